// File: rtl/elevator_ctrl.sv
// Car motion controller for a 4-floor elevator: pops one request, travels floor by floor, holds the door.
// Optional `ELEV_DOOR_HOLD_EN` adds the door_hold input that keeps the door open while asserted.
module elevator_ctrl #(
  parameter int unsigned FLOOR_TICKS = 8,
  parameter int unsigned DOOR_TICKS  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qEmpty,
  input  logic [2:0] req,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic       done,
  output logic [1:0] floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open
);

  localparam int unsigned MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] FLOOR_LAST = CW'(FLOOR_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST  = CW'(DOOR_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_GRAB,
    S_MOVE,
    S_DOOR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    floor_q, floor_d;
  logic [1:0]    tgt_q, tgt_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    req_tgt;
  logic          req_vld;
  logic [1:0]    floor_step;

  always_comb begin
    req_tgt = '0;
    req_vld = 1'b1;
    case (req)
      3'b001:         req_tgt = 2'd0;
      3'b010, 3'b110: req_tgt = 2'd1;
      3'b011, 3'b111: req_tgt = 2'd2;
      3'b100:         req_tgt = 2'd3;
      default:        req_vld = 1'b0;
    endcase
  end

  // Saturating one-floor step in the current travel direction.
  always_comb begin
    floor_step = floor_q;
    if (dir_q && floor_q != 2'd3) begin
      floor_step = floor_q + 2'd1;
    end else if (!dir_q && floor_q != 2'd0) begin
      floor_step = floor_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!qEmpty) state_d = S_POP;
      end
      S_POP: state_d = S_GRAB;
      S_GRAB: begin
        if (!req_vld) begin
          state_d = S_IDLE;
        end else if (req_tgt == floor_q) begin
          state_d = S_DOOR;
          cnt_d   = '0;
        end else begin
          state_d = S_MOVE;
          tgt_d   = req_tgt;
          dir_d   = (req_tgt > floor_q);
          cnt_d   = '0;
        end
      end
      S_MOVE: begin
        if (cnt_q == FLOOR_LAST) begin
          cnt_d   = '0;
          floor_d = floor_step;
          if (floor_step == tgt_q) state_d = S_DOOR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DOOR: begin
`ifdef ELEV_DOOR_HOLD_EN
        if (door_hold) begin
          cnt_d = '0;
        end else
`endif
        if (cnt_q == DOOR_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      tgt_q   <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done      = (state_q == S_POP);
  assign moving    = (state_q == S_MOVE);
  assign door_open = (state_q == S_DOOR);
  assign floor     = floor_q;
  assign dir_up    = dir_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: per-transaction expected traces built from floor arithmetic.
// Define ELEV_DOOR_HOLD_EN to also exercise the door_hold extension.
`timescale 1ns/1ps
module tb_elevator_ctrl;

  localparam int unsigned FT = 4;
  localparam int unsigned DT = 3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       qEmpty = 1'b1;
  logic [2:0] req    = 3'b000;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic       done;
  logic [1:0] floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;

  elevator_ctrl #(
    .FLOOR_TICKS(FT),
    .DOOR_TICKS (DT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .qEmpty   (qEmpty),
    .req      (req),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .done     (done),
    .floor    (floor),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic [1:0] floor;
    logic       dir;
    logic       moving;
    logic       door;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mfloor   = 0;
  logic mdir     = 1'b1;

  function automatic obs_t observe();
    return {done, floor, dir_up, moving, door_open};
  endfunction

  function automatic obs_t idle_exp();
    return '{1'b0, 2'(mfloor), mdir, 1'b0, 1'b0};
  endfunction

  // Expected cycle trace from POP onward; the trailing IDLE is checked by the caller.
  function automatic void build_txn(input logic [2:0] code);
    int tgt;
    int n;
    logic d;
    exp_q.delete();
    exp_q.push_back('{1'b1, 2'(mfloor), mdir, 1'b0, 1'b0});
    exp_q.push_back('{1'b0, 2'(mfloor), mdir, 1'b0, 1'b0});
    case (code)
      3'b001:         tgt = 0;
      3'b010, 3'b110: tgt = 1;
      3'b011, 3'b111: tgt = 2;
      3'b100:         tgt = 3;
      default:        tgt = -1;
    endcase
    if (tgt < 0) return;
    if (tgt != mfloor) begin
      d = (tgt > mfloor);
      n = d ? tgt - mfloor : mfloor - tgt;
      for (int i = 0; i < n * int'(FT); i++) begin
        exp_q.push_back('{1'b0, 2'(d ? mfloor + i / int'(FT) : mfloor - i / int'(FT)), d, 1'b1, 1'b0});
      end
      mdir   = d;
      mfloor = tgt;
    end
    for (int i = 0; i < int'(DT); i++) begin
      exp_q.push_back('{1'b0, 2'(mfloor), mdir, 1'b0, 1'b1});
    end
  endfunction

  task automatic play_txn(input logic [2:0] code, input int gap, input string tag);
    obs_t o;
    obs_t e;
    for (int g = 0; g <= gap; g++) begin
      @(negedge clk);
      o = observe();
      e = idle_exp();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s idle: got %b want %b (done,floor,dir,moving,door)", tag, o, e);
      end
      qEmpty = (g == gap) ? 1'b0 : 1'b1;
      req    = 3'($urandom);
    end
    build_txn(code);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_checks++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s step %0d: got %b want %b (done,floor,dir,moving,door)", tag, i, o, exp_q[i]);
      end
      req    = (i == 1) ? code : 3'($urandom);
      qEmpty = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    obs_t e;
    e = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    qEmpty = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b want %b", c, o, e);
      end
      req = 3'($urandom);
    end
    mfloor = 0;
    mdir   = 1'b1;
  endtask

  task automatic test_directed();
    play_txn(3'b100, 1, "up_0_to_3");
    play_txn(3'b001, 2, "down_3_to_0");
    play_txn(3'b001, 1, "same_floor_0");
    play_txn(3'b000, 0, "invalid_000");
    play_txn(3'b101, 0, "invalid_101_b2b");
    play_txn(3'b110, 0, "b2b_2D");
    play_txn(3'b111, 0, "b2b_3D");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      play_txn(3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    obs_t e;
    play_txn(3'b001, 0, "home_floor0");
    @(negedge clk);
    qEmpty = 1'b0;
    req    = 3'b100;
    @(negedge clk);
    qEmpty = 1'b1;
    @(negedge clk);
    req = 3'b100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (moving !== 1'b1 || floor !== 2'(i / int'(FT))) begin
        n_fail++;
        $display("FAIL async_pre move %0d: got moving=%0b floor=%0d want moving=1 floor=%0d",
                 i, moving, floor, i / int'(FT));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    e = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    o = observe();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL async_reset immediate: got %b want %b", o, e);
    end
    @(negedge clk);
    o = observe();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL async_reset held: got %b want %b", o, e);
    end
    rst_n  = 1'b1;
    mfloor = 0;
    mdir   = 1'b1;
    play_txn(3'b011, 1, "after_reset_to_2");
  endtask

`ifdef ELEV_DOOR_HOLD_EN
  task automatic test_door_hold();
    logic [2:0] codes [4];
    int   ndoor;
    codes = '{3'b001, 3'b010, 3'b011, 3'b100};
    ndoor = 0;
    @(negedge clk);
    qEmpty = 1'b0;
    @(negedge clk);
    qEmpty = 1'b1;
    @(negedge clk);
    req = codes[mfloor];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (door_open === 1'b1) ndoor++;
      door_hold = (door_open === 1'b1) && (ndoor <= 5);
    end
    door_hold = 1'b0;
    n_checks++;
    if (ndoor != 5 + int'(DT)) begin
      n_fail++;
      $display("FAIL door_hold length: got %0d want %0d", ndoor, 5 + int'(DT));
    end
    n_checks++;
    if (floor !== 2'(mfloor) || moving !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL door_hold end: got floor=%0d moving=%0b done=%0b want floor=%0d 0 0",
               floor, moving, done, mfloor);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_async_reset();
`ifdef ELEV_DOOR_HOLD_EN
    test_door_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
